cfg_fetch_master: RTL and testbench

- Wishbone master inside the encoder/decoder core that consumes the channel configuration held by the config interface block.
- After reset it polls the config-done register and reads all 32 3-bit channel rate registers into a local table.
- It then writes 1 to the core-ready register and serves single-cycle rate lookups to the core datapath.
- One instance sits on the encoder-side Wishbone port and one on the decoder-side port.

---
 rtl/cfg_fetch_master.sv | 162 ++++++++++++++++
 tb/tb_cfg_fetch_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_fetch_master.sv
// Wishbone master that waits for the config block to report done, copies the
// 32 channel rate registers into a local table, signals core-ready, then serves lookups.
module cfg_fetch_master #(
  parameter logic [31:0] DONE_ADDR   = 32'h0000_0080,
  parameter logic [31:0] READY_ADDR  = 32'h0000_0084,
  parameter int          POLL_GAP    = 16,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_refresh,
  input  logic [4:0]  i_ch_sel,
  output logic [2:0]  o_ch_rate,
  output logic        o_rate_valid,
  output logic        o_cfg_loaded,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_WAIT, S_FETCH, S_SIGNAL, S_READY
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } wb_req_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [4:0]        ch;
  logic [7:0]        tmr;
  logic [31:0][2:0]  tbl;
  wb_req_t           req;

  logic unused_dat;
  assign unused_dat = ^i_wb_dat[31:3];

  // Request for the transfer the current state would issue next; WAIT re-polls.
  always_comb begin
    req = '0;
    case (state)
      S_FETCH:  req.adr = {25'd0, ch, 2'b00};
      S_SIGNAL: begin
        req.adr = READY_ADDR;
        req.we  = 1'b1;
        req.dat = 32'h1;
      end
      default:  req.adr = DONE_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= '0;
      tmr          <= '0;
      tbl          <= '0;
      o_wb_adr     <= '0;
      o_wb_sel     <= '0;
      o_wb_we      <= 1'b0;
      o_wb_dat     <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_ch_rate    <= '0;
      o_rate_valid <= 1'b0;
      o_cfg_loaded <= 1'b0;
      o_fetch_err  <= 1'b0;
    end else begin
      // Non-blocking read of the table: a same-cycle write is seen one cycle later.
      o_ch_rate <= tbl[i_ch_sel];
      case (state)
        S_IDLE: state <= S_POLL;

        S_WAIT: begin
          if (tmr == GAP_LAST) begin
            state    <= S_POLL;
            tmr      <= '0;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_adr <= req.adr;
            o_wb_we  <= req.we;
            o_wb_dat <= req.dat;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end

        S_POLL, S_FETCH, S_SIGNAL: begin
          if (!o_wb_cyc) begin
            // Bus was idle for at least one cycle; start (or retry) the transfer.
            tmr      <= '0;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_adr <= req.adr;
            o_wb_we  <= req.we;
            o_wb_dat <= req.dat;
          end else if (i_wb_err || i_wb_ack || tmr == TMO_LAST) begin
            tmr      <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_sel <= '0;
            o_wb_adr <= '0;
            o_wb_we  <= 1'b0;
            o_wb_dat <= '0;
            if (i_wb_err || !i_wb_ack) begin
              o_fetch_err <= 1'b1;
            end else begin
              case (state)
                S_POLL: begin
                  if (i_wb_dat[0]) begin
                    state <= S_FETCH;
                    ch    <= '0;
                  end else begin
                    state <= S_WAIT;
                  end
                end
                S_FETCH: begin
                  tbl[ch] <= i_wb_dat[2:0];
                  if (ch == 5'd31) state <= S_SIGNAL;
                  else             ch    <= ch + 5'd1;
                end
                default: begin
                  state        <= S_READY;
                  o_cfg_loaded <= 1'b1;
                  o_rate_valid <= 1'b1;
                end
              endcase
            end
          end else begin
            tmr <= tmr + 8'd1;
          end
        end

        S_READY: begin
          if (i_refresh) begin
            state        <= S_POLL;
            o_cfg_loaded <= 1'b0;
            o_rate_valid <= 1'b0;
            o_fetch_err  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_fetch_master.sv
// Directed bench for cfg_fetch_master: negedge-driven Wishbone slave model that
// logs every transfer, plus one task per scenario with inline checks.
module tb_cfg_fetch_master;
  localparam logic [31:0] DONE  = 32'h0000_0080;
  localparam logic [31:0] READY = 32'h0000_0084;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb;
  logic [31:0] rdat = '0;
  logic        ack = 1'b0, err = 1'b0;
  logic        i_refresh = 1'b0;
  logic [4:0]  i_ch_sel = '0;
  logic [2:0]  o_ch_rate;
  logic        o_rate_valid, o_cfg_loaded, o_fetch_err;

  cfg_fetch_master dut (
    .clk(clk), .reset(reset),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .i_wb_dat(rdat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_ack(ack), .i_wb_err(err), .i_refresh(i_refresh), .i_ch_sel(i_ch_sel),
    .o_ch_rate(o_ch_rate), .o_rate_valid(o_rate_valid),
    .o_cfg_loaded(o_cfg_loaded), .o_fetch_err(o_fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // slave model state and stimulus knobs
  int          cyc_n = 0, stb_bad = 0, done_zeros = 0;
  logic        cyc_q = 1'b0;
  bit          pend = 0, stall_now = 0, err_now = 0;
  bit          stall_arm = 0, err_arm = 0, data_mode = 0;
  logic [31:0] stall_addr = '0, err_addr = '0, rsp = '0;
  logic [2:0]  val;
  logic [31:0] q_adr[$], q_dat[$];
  logic        q_we[$];
  logic [3:0]  q_sel[$];
  int          q_rise[$], q_fall[$];

  // Acks one full cycle after stb is first seen, so the master samples ack at its second edge.
  always @(negedge clk) begin
    cyc_n++;
    if (o_wb_stb !== o_wb_cyc) stb_bad++;
    if (!o_wb_cyc) begin
      ack = 0; err = 0; rdat = '0; pend = 0;
      if (cyc_q) q_fall.push_back(cyc_n);
    end else if (!cyc_q) begin
      q_adr.push_back(o_wb_adr); q_we.push_back(o_wb_we); q_dat.push_back(o_wb_dat);
      q_sel.push_back(o_wb_sel); q_rise.push_back(cyc_n);
      stall_now = stall_arm && (o_wb_adr == stall_addr);
      if (stall_now) stall_arm = 0;
      err_now = err_arm && (o_wb_adr == err_addr);
      if (err_now) err_arm = 0;
      if (o_wb_adr == DONE) begin
        rsp = (done_zeros > 0) ? 32'h0 : 32'h1;
        if (done_zeros > 0) done_zeros--;
      end else if (o_wb_adr == READY) begin
        rsp = '0;
      end else begin
        val = data_mode ? 3'(3'd7 - o_wb_adr[4:2]) : o_wb_adr[4:2];
        if (err_now) val = ~val;
        rsp = {29'h15555555, val};
      end
      pend = 1;
    end else if (pend) begin
      pend = 0;
      if (!stall_now) begin ack = 1; err = err_now; rdat = rsp; end
    end else begin
      ack = 0; err = 0;
    end
    cyc_q = o_wb_cyc;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clr_log();
    q_adr.delete(); q_dat.delete(); q_we.delete(); q_sel.delete();
    q_rise.delete(); q_fall.delete();
  endtask

  task automatic wait_loaded(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (o_cfg_loaded) begin ok = 1; break; end
    end
  endtask

  task automatic wait_xfers(input int n, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (q_adr.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic restart();
    reset = 1; tick(); tick();
    clr_log();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; repeat (3) tick();
    n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_cyc got %b want 0", o_wb_cyc); end
    n_checks++; if (o_wb_stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb got %b want 0", o_wb_stb); end
    n_checks++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== 69'd0) begin n_fail++; $display("FAIL rst_bus adr %h dat %h sel %h we %b want 0", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we); end
    n_checks++; if (o_ch_rate !== 3'd0) begin n_fail++; $display("FAIL rst_rate got %0d want 0", o_ch_rate); end
    n_checks++; if ({o_rate_valid, o_cfg_loaded, o_fetch_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {o_rate_valid, o_cfg_loaded, o_fetch_err}); end
  endtask

  task automatic test_clean_fetch();
    bit ok;
    clr_log();
    reset = 0;
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL clean_loaded timeout got %b want 1", ok); end
    n_checks++; if (q_adr.size() !== 34) begin n_fail++; $display("FAIL clean_count got %0d want 34", q_adr.size()); end
    for (int i = 0; i < 34 && i < q_adr.size(); i++) begin
      logic [31:0] ea, ed;
      logic ew;
      ea = (i == 0) ? DONE : (i == 33) ? READY : 32'(4 * (i - 1));
      ew = (i == 33);
      ed = (i == 33) ? 32'h1 : 32'h0;
      n_checks++; if (q_adr[i] !== ea || q_we[i] !== ew || q_dat[i] !== ed || q_sel[i] !== 4'hF) begin
        n_fail++; $display("FAIL clean_xfer%0d adr %h we %b dat %h sel %h want %h %b %h F", i, q_adr[i], q_we[i], q_dat[i], q_sel[i], ea, ew, ed);
      end
    end
    for (int i = 0; i < 34 && i < q_fall.size(); i++) begin
      n_checks++; if (q_fall[i] - q_rise[i] !== 2) begin n_fail++; $display("FAIL clean_len%0d got %0d want 2", i, q_fall[i] - q_rise[i]); end
      if (i < 33 && i + 1 < q_rise.size()) begin
        n_checks++; if (q_rise[i+1] - q_fall[i] !== 1) begin n_fail++; $display("FAIL clean_idle%0d got %0d want 1", i, q_rise[i+1] - q_fall[i]); end
      end
    end
    n_checks++; if (stb_bad !== 0) begin n_fail++; $display("FAIL stb_eq_cyc got %0d bad cycles want 0", stb_bad); end
    n_checks++; if ({o_rate_valid, o_fetch_err} !== 2'b10) begin n_fail++; $display("FAIL clean_flags valid/err got %b want 10", {o_rate_valid, o_fetch_err}); end
    i_ch_sel = 5'd13; tick();
    n_checks++; if (o_ch_rate !== 3'd5) begin n_fail++; $display("FAIL clean_ch13 got %0d want 5", o_ch_rate); end
    for (int n = 0; n < 32; n++) begin
      i_ch_sel = 5'(n); tick();
      n_checks++; if (o_ch_rate !== 3'(n % 8)) begin n_fail++; $display("FAIL clean_tbl%0d got %0d want %0d", n, o_ch_rate, n % 8); end
    end
  endtask

  task automatic test_poll_wait();
    bit ok;
    done_zeros = 3;
    restart();
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL poll_loaded timeout got %b want 1", ok); end
    n_checks++; if (q_adr.size() !== 37) begin n_fail++; $display("FAIL poll_count got %0d want 37", q_adr.size()); end
    for (int i = 0; i < 4 && i < q_adr.size(); i++) begin
      n_checks++; if (q_adr[i] !== DONE) begin n_fail++; $display("FAIL poll_adr%0d got %h want %h", i, q_adr[i], DONE); end
    end
    for (int i = 0; i < 3 && i + 1 < q_rise.size(); i++) begin
      n_checks++; if (q_rise[i+1] - q_fall[i] !== 16) begin n_fail++; $display("FAIL poll_gap%0d got %0d want 16", i, q_rise[i+1] - q_fall[i]); end
    end
    if (q_adr.size() > 4) begin
      n_checks++; if (q_adr[4] !== 32'h0) begin n_fail++; $display("FAIL poll_first_fetch got %h want 0", q_adr[4]); end
    end
    n_checks++; if (o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL poll_err got %b want 0", o_fetch_err); end
  endtask

  task automatic test_timeout();
    bit ok;
    stall_arm = 1; stall_addr = 32'h1C;
    restart();
    wait_loaded(4000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_loaded timeout got %b want 1", ok); end
    n_checks++; if (q_adr.size() !== 35) begin n_fail++; $display("FAIL tmo_count got %0d want 35", q_adr.size()); end
    if (q_adr.size() > 9 && q_fall.size() > 8) begin
      n_checks++; if (q_adr[8] !== 32'h1C || q_adr[9] !== 32'h1C) begin n_fail++; $display("FAIL tmo_retry_adr got %h %h want 1c 1c", q_adr[8], q_adr[9]); end
      n_checks++; if (q_fall[8] - q_rise[8] !== 64) begin n_fail++; $display("FAIL tmo_len got %0d want 64", q_fall[8] - q_rise[8]); end
      n_checks++; if (q_rise[9] - q_fall[8] !== 1) begin n_fail++; $display("FAIL tmo_idle got %0d want 1", q_rise[9] - q_fall[8]); end
    end
    n_checks++; if (o_fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", o_fetch_err); end
    for (int n = 0; n < 32; n++) begin
      i_ch_sel = 5'(n); tick();
      n_checks++; if (o_ch_rate !== 3'(n % 8)) begin n_fail++; $display("FAIL tmo_tbl%0d got %0d want %0d", n, o_ch_rate, n % 8); end
    end
  endtask

  task automatic test_err();
    bit ok;
    err_arm = 1; err_addr = 32'h50;
    i_ch_sel = 5'd20;
    restart();
    wait_xfers(23, 3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_retry timeout got %b want 1", ok); end
    n_checks++; if (o_ch_rate !== 3'd0) begin n_fail++; $display("FAIL err_nowrite got %0d want 0", o_ch_rate); end
    if (q_adr.size() > 22) begin
      n_checks++; if (q_adr[21] !== 32'h50 || q_adr[22] !== 32'h50) begin n_fail++; $display("FAIL err_retry_adr got %h %h want 50 50", q_adr[21], q_adr[22]); end
    end
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_loaded timeout got %b want 1", ok); end
    n_checks++; if (o_fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", o_fetch_err); end
    tick();
    n_checks++; if (o_ch_rate !== 3'd4) begin n_fail++; $display("FAIL err_ch20 got %0d want 4", o_ch_rate); end
    i_refresh = 1; tick(); i_refresh = 0;
    n_checks++; if ({o_fetch_err, o_cfg_loaded, o_rate_valid} !== 3'b000) begin n_fail++; $display("FAIL err_refresh_clr got %b want 000", {o_fetch_err, o_cfg_loaded, o_rate_valid}); end
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_reload timeout got %b want 1", ok); end
  endtask

  task automatic test_refresh();
    bit ok;
    data_mode = 1;
    clr_log();
    i_refresh = 1; tick(); i_refresh = 0;
    n_checks++; if ({o_rate_valid, o_cfg_loaded} !== 2'b00) begin n_fail++; $display("FAIL ref_drop got %b want 00", {o_rate_valid, o_cfg_loaded}); end
    wait_xfers(10, 1000, ok);
    n_checks++; if (ok !== 1'b1 || o_rate_valid !== 1'b0) begin n_fail++; $display("FAIL ref_midvalid ok %b valid %b want 1 0", ok, o_rate_valid); end
    i_refresh = 1; tick(); i_refresh = 0;
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ref_loaded timeout got %b want 1", ok); end
    n_checks++; if (q_adr.size() !== 34) begin n_fail++; $display("FAIL ref_count got %0d want 34", q_adr.size()); end
    i_ch_sel = 5'd2; tick();
    n_checks++; if (o_ch_rate !== 3'd5) begin n_fail++; $display("FAIL ref_ch2 got %0d want 5", o_ch_rate); end
    for (int n = 0; n < 32; n++) begin
      i_ch_sel = 5'(n); tick();
      n_checks++; if (o_ch_rate !== 3'(7 - n)) begin n_fail++; $display("FAIL ref_tbl%0d got %0d want %0d", n, o_ch_rate, 3'(7 - n)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    data_mode = 0; done_zeros = 5;
    clr_log();
    i_refresh = 1; tick(); i_refresh = 0;
    wait_xfers(17, 3000, ok);
    n_checks++; if (ok !== 1'b1 || q_adr[16] !== 32'h28 || o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL mid_inflight ok %b adr %h cyc %b want 1 28 1", ok, q_adr[16], o_wb_cyc); end
    reset = 1; tick();
    n_checks++; if ({o_wb_cyc, o_wb_stb, o_wb_sel, o_wb_we} !== 7'd0 || o_wb_adr !== 32'd0) begin n_fail++; $display("FAIL mid_bus cyc %b stb %b sel %h adr %h want 0", o_wb_cyc, o_wb_stb, o_wb_sel, o_wb_adr); end
    n_checks++; if ({o_rate_valid, o_cfg_loaded, o_fetch_err, o_ch_rate} !== 6'd0) begin n_fail++; $display("FAIL mid_outs got %b want 0", {o_rate_valid, o_cfg_loaded, o_fetch_err, o_ch_rate}); end
    tick();
    clr_log(); done_zeros = 5;
    reset = 0;
    for (int n = 0; n < 32; n++) begin
      i_ch_sel = 5'(n); tick();
      n_checks++; if (o_ch_rate !== 3'd0) begin n_fail++; $display("FAIL mid_tbl%0d got %0d want 0", n, o_ch_rate); end
    end
    n_checks++; if (q_adr.size() < 1 || q_adr[0] !== DONE) begin n_fail++; $display("FAIL mid_restart size %0d want first adr %h", q_adr.size(), DONE); end
    wait_loaded(3000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_loaded timeout got %b want 1", ok); end
    i_ch_sel = 5'd10; tick();
    n_checks++; if (o_ch_rate !== 3'd2) begin n_fail++; $display("FAIL mid_ch10 got %0d want 2", o_ch_rate); end
  endtask

  initial begin
    test_reset();
    test_clean_fetch();
    test_poll_wait();
    test_timeout();
    test_err();
    test_refresh();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
